quick_attack_sequencer: RTL and testbench
=========================================

QUICK_ATTACK_SEQUENCER -- requirements
Module: quick_attack_sequencer

Interface
REQ-001 The block SHALL have parameter DRAW_TIMEOUT, default 4095, meaning the maximum number of cycles allowed in DRAW or ERASE before abort.
REQ-002 The block SHALL have parameter FRAME_W, default 11, meaning the width of frame_count.
REQ-003 The block SHALL have port clock  input  1  system clock, rising-edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to run one quick-attack sequence.
REQ-006 The block SHALL have port done_pikachu  input  1  single-cycle pulse: sprite draw or erase pass finished.
REQ-007 The block SHALL have port done_animate  input  1  single-cycle animation frame tick.
REQ-008 The block SHALL have port done_quick_attack  input  1  level: attack duration expired.
REQ-009 The block SHALL have port enable_animate  output  1  enables the frame timer and duration counter.
REQ-010 The block SHALL have port enable_p_qa  output  1  single-cycle x-step strobe to the motion stage.
REQ-011 The block SHALL have port enable_draw_pika  output  1  enables the sprite pixel walker.
REQ-012 The block SHALL have port erase  output  1  selects background colour in place of sprite colour.
REQ-013 The block SHALL have port plot  output  1  VGA write enable.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port attack_done  output  1  single-cycle completion pulse.
REQ-016 The block SHALL have port timeout_err  output  1  sticky: a draw/erase pass exceeded DRAW_TIMEOUT.
REQ-017 The block SHALL have port frame_count  output  FRAME_W  frames elapsed in the current attack.

Function
REQ-018 The FSM SHALL have states IDLE, DRAW, WAIT_FRAME, ERASE, MOVE, DONE, with all outputs decoded from the registered state (Moore).
REQ-019 In IDLE, start=1 SHALL transition to DRAW next cycle, clear frame_count and clear timeout_err; start in any other state SHALL be ignored.
REQ-020 In DRAW, outputs SHALL be enable_draw_pika=1, plot=1, erase=0, enable_animate=1; done_pikachu=1 SHALL transition to WAIT_FRAME.
REQ-021 In WAIT_FRAME, outputs SHALL be enable_animate=1 and all others 0; on done_animate=1 the block SHALL increment frame_count, then go to DONE if done_quick_attack=1 in that same cycle, else to ERASE.
REQ-022 In ERASE, outputs SHALL be enable_draw_pika=1, plot=1, erase=1, enable_animate=1; done_pikachu=1 SHALL transition to MOVE.
REQ-023 MOVE SHALL last exactly one cycle with enable_p_qa=1 and enable_animate=1, then go to DRAW.
REQ-024 DONE SHALL last exactly one cycle with attack_done=1, then go to IDLE.
REQ-025 A cycle counter SHALL run only in DRAW/ERASE, clear on every state entry, and on reaching DRAW_TIMEOUT SHALL set timeout_err and force IDLE.
REQ-026 If done_pikachu and the timeout coincide, done_pikachu SHALL take priority and timeout_err SHALL NOT be set.
REQ-027 done_animate outside WAIT_FRAME and done_pikachu outside DRAW/ERASE SHALL be ignored.
REQ-028 frame_count SHALL saturate at all-ones (no wrap).
REQ-029 enable_p_qa SHALL never be high for two consecutive cycles.

Reset
REQ-030 reset=1 at a clock edge SHALL force state IDLE, frame_count=0, timeout_err=0, watchdog=0, and all other outputs 0 from the next cycle, including mid-sequence.
REQ-031 reset SHALL take priority over start and all done inputs.

Structure
REQ-032 State encoding and the DRAW_TIMEOUT and FRAME_W defaults SHALL reside in shared package quick_attack_pkg.
REQ-033 The watchdog SHALL be a sub-module named draw_watchdog (clear, count-enable, terminal-count flag).

Verification
REQ-034 Start pulse, done_pikachu after 100 cycles -> DRAW for 100 cycles with plot=1, erase=0, then WAIT_FRAME.
REQ-035 Full loop: done_animate with done_quick_attack=0 -> ERASE (erase=1), done_pikachu -> one-cycle enable_p_qa, back to DRAW; frame_count=1.
REQ-036 done_animate together with done_quick_attack=1 on the third frame -> DONE, attack_done high for exactly 1 cycle, frame_count=3, busy low on the next cycle.
REQ-037 DRAW_TIMEOUT=16 with no done_pikachu -> timeout_err=1 and IDLE after 16 DRAW cycles; done_pikachu on cycle 16 -> WAIT_FRAME, timeout_err=0.
REQ-038 reset asserted in ERASE -> all outputs 0 and frame_count=0 on the next cycle; start during busy has no effect.

Source files
------------

// File: rtl/quick_attack_pkg.sv
// Shared definitions for the quick-attack sequencer: state encoding, default
// parameters and the Moore output decode used by the top level.
package quick_attack_pkg;

    localparam int QA_DRAW_TIMEOUT = 4095;
    localparam int QA_FRAME_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT_FRAME,
        S_ERASE,
        S_MOVE,
        S_DONE
    } qa_state_t;

    typedef struct packed {
        logic enable_animate;
        logic enable_p_qa;
        logic enable_draw_pika;
        logic erase;
        logic plot;
        logic busy;
        logic attack_done;
    } qa_ctrl_t;

    function automatic qa_ctrl_t qa_decode(input qa_state_t state);
        qa_ctrl_t c;
        c = '0;
        case (state)
            S_DRAW:       begin c.enable_animate = 1'b1; c.enable_draw_pika = 1'b1; c.plot = 1'b1; end
            S_WAIT_FRAME: c.enable_animate = 1'b1;
            S_ERASE:      begin c.enable_animate = 1'b1; c.enable_draw_pika = 1'b1; c.plot = 1'b1;
                                c.erase = 1'b1; end
            S_MOVE:       begin c.enable_animate = 1'b1; c.enable_p_qa = 1'b1; end
            S_DONE:       c.attack_done = 1'b1;
            default:      c = '0;
        endcase
        c.busy = (state != S_IDLE);
        return c;
    endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Cycle counter bounding a single sprite draw/erase pass; terminal is raised
// during the LIMIT-th counted cycle so the caller can abort on that edge.
module draw_watchdog #(
    parameter int LIMIT = 4095
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (count_en && !terminal)
            count <= count + CW'(1);
    end

    assign terminal = count_en && (count == LAST);

endmodule

// File: rtl/quick_attack_sequencer.sv
// Moore sequencer for the quick-attack animation: draw, wait a frame, erase,
// step, repeat until the attack duration expires, guarded by a pass watchdog.
module quick_attack_sequencer
    import quick_attack_pkg::*;
#(
    parameter int DRAW_TIMEOUT = QA_DRAW_TIMEOUT,
    parameter int FRAME_W      = QA_FRAME_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               done_pikachu,
    input  logic               done_animate,
    input  logic               done_quick_attack,
    output logic               enable_animate,
    output logic               enable_p_qa,
    output logic               enable_draw_pika,
    output logic               erase,
    output logic               plot,
    output logic               busy,
    output logic               attack_done,
    output logic               timeout_err,
    output logic [FRAME_W-1:0] frame_count
);

    qa_state_t state, next_state;
    qa_ctrl_t  ctrl;
    logic      in_pass;
    logic      wd_terminal;
    logic      pass_timeout;

    assign in_pass      = (state == S_DRAW) || (state == S_ERASE);
    // A finishing pass wins over a coincident watchdog expiry.
    assign pass_timeout = in_pass && wd_terminal && !done_pikachu;

    draw_watchdog #(.LIMIT(DRAW_TIMEOUT)) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (next_state != state),
        .count_en (in_pass),
        .terminal (wd_terminal)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (start) next_state = S_DRAW;
            S_DRAW:       if (done_pikachu) next_state = S_WAIT_FRAME;
                          else if (wd_terminal) next_state = S_IDLE;
            S_WAIT_FRAME: if (done_animate) next_state = done_quick_attack ? S_DONE : S_ERASE;
            S_ERASE:      if (done_pikachu) next_state = S_MOVE;
                          else if (wd_terminal) next_state = S_IDLE;
            S_MOVE:       next_state = S_DRAW;
            S_DONE:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl             = qa_decode(state);
        enable_animate   = ctrl.enable_animate;
        enable_p_qa      = ctrl.enable_p_qa;
        enable_draw_pika = ctrl.enable_draw_pika;
        erase            = ctrl.erase;
        plot             = ctrl.plot;
        busy             = ctrl.busy;
        attack_done      = ctrl.attack_done;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_WAIT_FRAME && done_animate && frame_count != '1)
                frame_count <= frame_count + FRAME_W'(1);
            if (pass_timeout)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quick_attack_sequencer.sv
// Directed bench: a vector table walks the main attack loop, hand sequences
// cover long passes, watchdog expiry in DRAW/ERASE and frame saturation.
module tb_quick_attack_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0, start = 1'b0, done_pikachu = 1'b0, done_animate = 1'b0, done_quick_attack = 1'b0;

    logic        a_anim, a_pqa, a_draw, a_erase, a_plot, a_busy, a_done, a_te;
    logic [10:0] a_fc;
    logic        b_anim, b_pqa, b_draw, b_erase, b_plot, b_busy, b_done, b_te;
    logic [1:0]  b_fc;

    int checks = 0;
    int errors = 0;

    // Expected output bundles {enable_animate, enable_p_qa, enable_draw_pika, erase, plot, busy, attack_done}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_DRAW  = 7'b1010110;
    localparam logic [6:0] O_WAIT  = 7'b1000010;
    localparam logic [6:0] O_ERASE = 7'b1011110;
    localparam logic [6:0] O_MOVE  = 7'b1100010;
    localparam logic [6:0] O_DONE  = 7'b0000011;

    wire [6:0] a_outs = {a_anim, a_pqa, a_draw, a_erase, a_plot, a_busy, a_done};
    wire [6:0] b_outs = {b_anim, b_pqa, b_draw, b_erase, b_plot, b_busy, b_done};

    quick_attack_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .done_pikachu(done_pikachu),
        .done_animate(done_animate), .done_quick_attack(done_quick_attack),
        .enable_animate(a_anim), .enable_p_qa(a_pqa), .enable_draw_pika(a_draw), .erase(a_erase),
        .plot(a_plot), .busy(a_busy), .attack_done(a_done), .timeout_err(a_te), .frame_count(a_fc)
    );

    quick_attack_sequencer #(.DRAW_TIMEOUT(16), .FRAME_W(2)) dut_wd (
        .clock(clock), .reset(reset), .start(start), .done_pikachu(done_pikachu),
        .done_animate(done_animate), .done_quick_attack(done_quick_attack),
        .enable_animate(b_anim), .enable_p_qa(b_pqa), .enable_draw_pika(b_draw), .erase(b_erase),
        .plot(b_plot), .busy(b_busy), .attack_done(b_done), .timeout_err(b_te), .frame_count(b_fc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    bit prev_pqa = 1'b0;
    always @(negedge clock) begin
        if (prev_pqa) check("p_qa_not_consecutive", {31'd0, a_pqa}, 32'd0);
        prev_pqa <= (a_pqa === 1'b1);
    end

    // Drive inputs for one clock edge, then sample 1 time unit after it.
    task automatic apply(input logic r, input logic s, input logic dp, input logic da, input logic dqa);
        reset = r; start = s; done_pikachu = dp; done_animate = da; done_quick_attack = dqa;
        @(posedge clock);
        #1;
        reset = 1'b0; start = 1'b0; done_pikachu = 1'b0; done_animate = 1'b0; done_quick_attack = 1'b0;
    endtask

    typedef struct {
        logic        rst, st, dp, da, dqa;
        logic [6:0]  outs;
        logic [10:0] fc;
        logic        te;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic st, input logic dp, input logic da,
                               input logic dqa, input logic [6:0] outs, input logic [10:0] fc);
        vec_t x;
        x.rst = rst; x.st = st; x.dp = dp; x.da = da; x.dqa = dqa;
        x.outs = outs; x.fc = fc; x.te = 1'b0;
        return x;
    endfunction

    vec_t vecs[21];

    initial begin
        vecs[0]  = v(1, 0, 0, 0, 0, O_IDLE,  0);  // reset
        vecs[1]  = v(0, 1, 0, 0, 0, O_DRAW,  0);  // start
        vecs[2]  = v(0, 1, 0, 1, 0, O_DRAW,  0);  // start and done_animate ignored in DRAW
        vecs[3]  = v(0, 0, 1, 0, 0, O_WAIT,  0);
        vecs[4]  = v(0, 0, 1, 0, 0, O_WAIT,  0);  // done_pikachu ignored in WAIT_FRAME
        vecs[5]  = v(0, 0, 0, 1, 0, O_ERASE, 1);
        vecs[6]  = v(0, 0, 0, 0, 0, O_ERASE, 1);
        vecs[7]  = v(0, 0, 1, 0, 0, O_MOVE,  1);
        vecs[8]  = v(0, 0, 0, 0, 0, O_DRAW,  1);  // MOVE lasts one cycle
        vecs[9]  = v(0, 0, 1, 0, 0, O_WAIT,  1);
        vecs[10] = v(0, 0, 0, 1, 0, O_ERASE, 2);
        vecs[11] = v(0, 0, 1, 0, 0, O_MOVE,  2);
        vecs[12] = v(0, 1, 0, 0, 0, O_DRAW,  2);
        vecs[13] = v(0, 0, 1, 0, 0, O_WAIT,  2);
        vecs[14] = v(0, 0, 0, 1, 1, O_DONE,  3);  // third frame ends the attack
        vecs[15] = v(0, 0, 0, 0, 0, O_IDLE,  3);
        vecs[16] = v(0, 0, 0, 1, 0, O_IDLE,  3);  // done_animate ignored in IDLE
        vecs[17] = v(0, 1, 0, 0, 0, O_DRAW,  0);  // restart clears frame_count
        vecs[18] = v(0, 0, 1, 0, 0, O_WAIT,  0);
        vecs[19] = v(0, 0, 0, 1, 0, O_ERASE, 1);
        vecs[20] = v(1, 1, 1, 0, 0, O_IDLE,  0);  // reset in ERASE beats done_pikachu

        #2;
        for (int i = 0; i < 21; i++) begin
            apply(vecs[i].rst, vecs[i].st, vecs[i].dp, vecs[i].da, vecs[i].dqa);
            check($sformatf("vec%0d_outs", i), {25'd0, a_outs}, {25'd0, vecs[i].outs});
            check($sformatf("vec%0d_frame", i), {21'd0, a_fc}, {21'd0, vecs[i].fc});
            check($sformatf("vec%0d_timeout", i), {31'd0, a_te}, {31'd0, vecs[i].te});
        end

        // Long draw pass: 100 cycles of DRAW before done_pikachu.
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        check("long_draw_c1", {25'd0, a_outs}, {25'd0, O_DRAW});
        for (int c = 2; c <= 100; c++) begin
            apply(0, 0, 0, 0, 0);
            check($sformatf("long_draw_c%0d", c), {25'd0, a_outs}, {25'd0, O_DRAW});
        end
        apply(0, 0, 1, 0, 0);
        check("long_draw_to_wait", {25'd0, a_outs}, {25'd0, O_WAIT});

        // Watchdog expiry in DRAW on the 16th cycle.
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        for (int c = 2; c <= 16; c++) apply(0, 0, 0, 0, 0);
        check("wd_draw_still_busy_c16", {25'd0, b_outs}, {25'd0, O_DRAW});
        check("wd_draw_no_err_c16", {31'd0, b_te}, 32'd0);
        apply(0, 0, 0, 0, 0);
        check("wd_draw_abort_idle", {25'd0, b_outs}, {25'd0, O_IDLE});
        check("wd_draw_err_set", {31'd0, b_te}, 32'd1);
        apply(0, 0, 0, 0, 0);
        check("wd_err_sticky", {31'd0, b_te}, 32'd1);

        // Restart clears the error; done_pikachu on cycle 16 beats the expiry.
        apply(0, 1, 0, 0, 0);
        check("wd_restart_clears_err", {31'd0, b_te}, 32'd0);
        for (int c = 2; c <= 16; c++) apply(0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        check("wd_tie_to_wait", {25'd0, b_outs}, {25'd0, O_WAIT});
        check("wd_tie_no_err", {31'd0, b_te}, 32'd0);

        // Fresh count in ERASE, expiry on its 16th cycle.
        apply(0, 0, 0, 1, 0);
        for (int c = 2; c <= 16; c++) apply(0, 0, 0, 0, 0);
        check("wd_erase_c16", {25'd0, b_outs}, {25'd0, O_ERASE});
        apply(0, 0, 0, 0, 0);
        check("wd_erase_abort_idle", {25'd0, b_outs}, {25'd0, O_IDLE});
        check("wd_erase_err_set", {31'd0, b_te}, 32'd1);

        // Five frames: 2-bit counter saturates at 3, default width reaches 5.
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        for (int f = 0; f < 5; f++) begin
            apply(0, 0, 1, 0, 0);
            apply(0, 0, 0, 1, 0);
            apply(0, 0, 1, 0, 0);
            apply(0, 0, 0, 0, 0);
        end
        check("sat_small_frame", {30'd0, b_fc}, 32'd3);
        check("sat_wide_frame", {21'd0, a_fc}, 32'd5);
        check("sat_back_in_draw", {25'd0, b_outs}, {25'd0, O_DRAW});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
